// File: rtl/saanvi_counter_if.sv
// saanvi_counter_if
//   Tiny Tapeout user-slot pin bundle for saanvi_counter.
//   master : the side driving the pads (wrapper or bench). It drives ena, ui_in and uio_in.
//   slave  : the counter core. It drives uo_out, uio_out and uio_oe.
//   ena     - design select; the count holds while low
//   ui_in   - [0] cnt_en, [1] dir (1=up), [2] load, [3] sat_mode, [7:4] step
//   uio_in  - parallel load value
//   uo_out  - current count
//   uio_out - constant 0x00
//   uio_oe  - constant 0x00 (all bidirectional pins are inputs)
interface saanvi_counter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/saanvi_counter.sv
// saanvi_counter
//   Programmable 8-bit up/down counter. It supports a step of 1..15 (a step of 0 counts
//   as 1), a parallel load, and optional saturation.
//   Ports:
//     clk - clock; all state changes on its rising edge
//     rst - synchronous, active-high reset; clears the count
//     bus - saanvi_counter_if.slave (TT pins; see the interface file for the bit map)
//   Priority: rst > !ena (hold) > load > cnt_en (up/down) > hold.
//   Build option: define SAANVI_COUNTER_SATURATE_EN to let ui_in[3] select clamping at
//   0x00/0xFF. Without it the counter always wraps modulo 256, and ui_in[3] is ignored.
module saanvi_counter (
    input  logic              clk,
    input  logic              rst,
    saanvi_counter_if.slave   bus
);

    logic [7:0] count_q, count_d;
    logic       cnt_en, dir, load;
    logic [3:0] step_eff;

    assign cnt_en   = bus.ui_in[0];
    assign dir      = bus.ui_in[1];
    assign load     = bus.ui_in[2];
    // A step of 0 would make the counter stall, so it is treated as 1.
    assign step_eff = (bus.ui_in[7:4] == 4'd0) ? 4'd1 : bus.ui_in[7:4];

`ifdef SAANVI_COUNTER_SATURATE_EN
    logic       sat_mode;
    logic [8:0] sum, diff;

    assign sat_mode = bus.ui_in[3];
    // The ninth bit carries out on overflow and borrows on underflow.
    assign sum  = {1'b0, count_q} + {5'd0, step_eff};
    assign diff = {1'b0, count_q} - {5'd0, step_eff};
`else
    logic       unused_sat_mode;
    logic [7:0] sum, diff;

    assign unused_sat_mode = bus.ui_in[3];
    assign sum  = count_q + {4'd0, step_eff};
    assign diff = count_q - {4'd0, step_eff};
`endif

    always_comb begin
        count_d = count_q;
        if (!bus.ena) begin
            count_d = count_q;
        end else if (load) begin
            count_d = bus.uio_in;
        end else if (cnt_en) begin
            if (dir) begin
                count_d = sum[7:0];
`ifdef SAANVI_COUNTER_SATURATE_EN
                if (sat_mode && sum[8]) count_d = 8'hFF;
`endif
            end else begin
                count_d = diff[7:0];
`ifdef SAANVI_COUNTER_SATURATE_EN
                if (sat_mode && diff[8]) count_d = 8'h00;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= 8'h00;
        else     count_q <= count_d;
    end

    assign bus.uo_out  = count_q;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_saanvi_counter.sv
// tb_saanvi_counter
//   Directed-vector bench for saanvi_counter. The expected counts are worked out by hand.
//   Saturation expectations follow SAANVI_COUNTER_SATURATE_EN.
module tb_saanvi_counter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    saanvi_counter_if bus ();

    saanvi_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Apply ui_in for one edge, then check uo_out just after that edge.
    task automatic tick(input logic [7:0] ui, input logic [7:0] exp, input string tag);
        bus.ui_in = ui;
        @(posedge clk);
        #1;
        chk(tag, bus.uo_out, exp);
    endtask

    task automatic chk_fixed(input string tag);
        chk({tag, "_uio_out"}, bus.uio_out, 8'h00);
        chk({tag, "_uio_oe"},  bus.uio_oe,  8'h00);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;

        // Reset: two edges.
        @(posedge clk);
        #1;
        chk_fixed("in_reset");
        tick(8'h00, 8'h00, "reset");
        chk_fixed("reset");
        rst = 1'b0;
        tick(8'h00, 8'h00, "post_reset_idle");

        // Count up with step 0, which counts as 1.
        tick(8'h03, 8'h01, "up1_a");
        tick(8'h03, 8'h02, "up1_b");
        tick(8'h03, 8'h03, "up1_c");
        tick(8'h03, 8'h04, "up1_d");
        tick(8'h03, 8'h05, "up1_e");
        bus.ena = 1'b0;
        tick(8'h03, 8'h05, "ena_hold_a");
        tick(8'h03, 8'h05, "ena_hold_b");
        tick(8'h03, 8'h05, "ena_hold_c");
        bus.ena = 1'b1;

        // Load wins over cnt_en, then the count wraps up through 0xFF.
        bus.uio_in = 8'hFE;
        tick(8'h07, 8'hFE, "load_fe");
        tick(8'h03, 8'hFF, "wrap_up_a");
        tick(8'h03, 8'h00, "wrap_up_b");

        // Step 3 up, then step 2 down through the 0x00 boundary.
        tick(8'h33, 8'h03, "step3_a");
        tick(8'h33, 8'h06, "step3_b");
        tick(8'h33, 8'h09, "step3_c");
        tick(8'h21, 8'h07, "down2_a");
        tick(8'h21, 8'h05, "down2_b");
        tick(8'h21, 8'h03, "down2_c");
        tick(8'h21, 8'h01, "down2_d");
        tick(8'h21, 8'hFF, "down2_e");
        tick(8'h21, 8'hFD, "down2_f");

        // Saturation, or wrap when it is compiled out.
        bus.uio_in = 8'hFD;
        tick(8'h04, 8'hFD, "load_fd");
`ifdef SAANVI_COUNTER_SATURATE_EN
        tick(8'h3B, 8'hFF, "sat_up_a");
        tick(8'h3B, 8'hFF, "sat_up_b");
`else
        tick(8'h3B, 8'h00, "nosat_up_a");
        tick(8'h3B, 8'h03, "nosat_up_b");
`endif
        bus.uio_in = 8'h01;
        tick(8'h04, 8'h01, "load_01");
`ifdef SAANVI_COUNTER_SATURATE_EN
        tick(8'h39, 8'h00, "sat_dn_a");
        tick(8'h39, 8'h00, "sat_dn_b");
`else
        tick(8'h39, 8'hFE, "nosat_dn_a");
        tick(8'h39, 8'hFB, "nosat_dn_b");
`endif

        // A load with sat_mode set is never clamped.
        bus.uio_in = 8'hFF;
        tick(8'hFF, 8'hFF, "load_ff_sat");

        // Reset in the middle of counting, and a restart from 0x00.
        bus.uio_in = 8'h40;
        tick(8'h04, 8'h40, "load_40");
        rst = 1'b1;
        tick(8'h03, 8'h00, "rst_mid");
        chk_fixed("rst_mid");
        rst = 1'b0;
        tick(8'h03, 8'h01, "rst_resume");

        // Reset while ena is low still clears the count.
        bus.uio_in = 8'h55;
        tick(8'h04, 8'h55, "load_55");
        bus.ena = 1'b0;
        rst     = 1'b1;
        tick(8'h07, 8'h00, "rst_ena_low");
        rst     = 1'b0;
        tick(8'h07, 8'h00, "ena_low_after_rst");
        chk_fixed("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/saanvi_counter.md
# saanvi_counter

Programmable 8-bit up/down counter core for the Tiny Tapeout user slot. It provides configurable step, a parallel load, and optional saturation. It sits directly under the `tt_um_saanvi_counter` top wrapper. The wrapper passes the standard TT pins through and derives `rst` from the pad-level `rst_n`.

## Interface
Parameters:
- none; the width is fixed at 8 bits.

Ports:
- `clk` input 1: the single clock. All state updates on its rising edge.
- `rst` input 1: reset. It is synchronous and active-high.
- `ena` input 1: design-select. When low, the count holds.
- `ui_in` input 8: control bits.
  - [0] `cnt_en`
  - [1] `dir` (1 = up, 0 = down)
  - [2] `load`
  - [3] `sat_mode`
  - [7:4] `step`
- `uio_in` input 8: parallel load value.
- `uo_out` output 8: current count, driven directly from the count register.
- `uio_out` output 8: tied to 0x00.
- `uio_oe` output 8: tied to 0x00, so all bidirectional pins are inputs.

## Operation
- The state is one 8-bit register `count`, and `uo_out = count`.
- Effective step is `s = (step == 0) ? 1 : step`, giving a range of 1..15.
- Next-state priority, evaluated at each rising `clk`:
  1. `rst` = 1: count is set to 0x00.
  2. `ena` = 0: count holds.
  3. `load` = 1: count is set to `uio_in`. `cnt_en`, `dir` and `step` are ignored.
  4. `cnt_en` = 1 and `dir` = 1: count is set to count + s.
  5. `cnt_en` = 1 and `dir` = 0: count is set to count − s.
  6. Otherwise, count holds.
- Arithmetic is 9-bit internally; the carry/borrow bit selects wrap or clamp.
- Wrap mode applies when `sat_mode` = 0, or always if saturation is compiled out. The result is modulo 256, for example 0xFE + 3 = 0x01 and 0x01 − 2 = 0xFF.
- Saturate mode applies when `sat_mode` = 1 and saturation is compiled in:
  - Up overflow clamps to 0xFF.
  - Down underflow clamps to 0x00.
  - At a limit, the count holds while the count continues in the same direction.
- Load is never clamped; any 8-bit value loads.
- `uio_out` and `uio_oe` are constant 0x00 in all states, including during reset.

## Timing
- Reset value: `uo_out` = 0x00. `uio_out` and `uio_oe` are always 0x00.
- Latency is one cycle. Inputs sampled at edge N are visible on `uo_out` after edge N, as a registered output.
- There is no combinational path from any input to `uo_out`.
- Reset mid-count: `rst` high at an edge overrides load and count. Counting resumes at the first edge with `rst` low, starting from 0x00.
- Reset while `ena` = 0 still clears the count.
- Simultaneous `load` and `cnt_en`: load wins for that cycle, and counting resumes on the next edge.
- Changing `dir`, `step` or `sat_mode` takes effect on the next edge. No pipeline flush is needed.

## Configuration
- Macro: `SAANVI_COUNTER_SATURATE_EN`.
- Defined: `ui_in[3]` selects saturate versus wrap, as described in Operation.
- Undefined: `ui_in[3]` is ignored, the counter always wraps modulo 256, and the clamp logic is absent from the netlist.

## Test plan
- Reset:
  - Stimulus: `rst`=1 for 2 edges with `ui_in`=0x00.
  - Required: `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0x00.
  - Then `rst`=0 with `ui_in`=0x00: `uo_out` stays 0x00.
- Count up:
  - Stimulus: from 0x00, `ena`=1, `ui_in`=0x03 (en, up, step 0 treated as 1), 5 edges.
  - Required: 0x01..0x05.
  - Then `ena`=0 for 3 edges: holds at 0x05.
- Load and wrap:
  - Stimulus: `uio_in`=0xFE and `ui_in`=0x07 (load with en) for 1 edge, then `ui_in`=0x03 for 2 edges.
  - Required: 0xFE after the load edge, then 0xFF, then 0x00.
- Step and down:
  - Stimulus: from 0x00, `ui_in`=0x33 (step 3, up) for 3 edges, then `ui_in`=0x21 (step 2, down) for 6 edges.
  - Required: 0x03, 0x06, 0x09, then 0x07, 0x05, 0x03, 0x01, 0xFF, 0xFD.
- Saturation:
  - Stimulus: load 0xFD, then `ui_in`=0x3B (step 3, sat, up) for 2 edges.
  - Required with the macro defined: 0xFF, 0xFF. Required without it: 0x00, 0x03.
  - Then, with the macro defined, load 0x01 and apply `ui_in`=0x39 (step 3, sat, down): required 0x00 and held.
- Reset mid-operation:
  - Stimulus: counting up at 0x40 with `ui_in`=0x03, assert `rst` for 1 edge, then release.
  - Required: 0x00 on the reset edge, then 0x01.
